// File: rtl/datapath_core.sv
// Execution datapath: register file, operand muxes, 3-bit ALU, flag register
// and memory address/data output registers driven by the sequencer control word.
module datapath_core #(
    parameter int M = 3,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic [N-1:0] offset,
    input  logic [M-1:0] waddr,
    input  logic [M-1:0] ra,
    input  logic [M-1:0] rb,
    input  logic [2:0]   op,
    input  logic         write,
    input  logic         reada,
    input  logic         readb,
    input  logic         ie,
    input  logic         mov_sel,
    input  logic         bypassa,
    input  logic         bypassb,
    input  logic         en,
    input  logic         oe,
    input  logic         addr_en,
    input  logic         data_en,
    input  logic         rw,
    output logic [N-1:0] dout,
    output logic [N-1:0] addr_out,
    output logic [N-1:0] data_out,
    output logic         mem_rw,
    output logic         o_flag,
    output logic         z_flag,
    output logic         n_flag
);

    localparam int unsigned DEPTH = 2 ** M;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_MOV = 3'b110,
        OP_INC = 3'b111
    } alu_op_e;

    logic [N-1:0] rf [DEPTH];
    logic [N-1:0] port_a, port_b;
    logic [N-1:0] a, b, y, wdata;
    logic [N-1:0] y_reg;
    logic         ovf;
    alu_op_e      alu_op;

    assign alu_op = alu_op_e'(op);
    assign port_a = reada ? rf[ra] : '0;
    assign port_b = readb ? rf[rb] : '0;
    assign a      = bypassa ? offset : port_a;
    assign b      = bypassb ? offset : port_b;

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (alu_op)
            OP_ADD: begin
                y   = a + b;
                ovf = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
            end
            OP_SUB: begin
                y   = a - b;
                ovf = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_MOV: y = a;
            OP_INC: begin
                y   = a + N'(1);
                ovf = !a[N-1] && y[N-1];
            end
            default: ;
        endcase
    end

    always_comb begin
        wdata = y;
        if (ie)
            wdata = din;
        else if (mov_sel)
            wdata = offset;
    end

    // Reads are combinational off the current array contents, so a same-cycle
    // write to the read address is only seen from the next cycle on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                rf[i] <= '0;
        end else if (write) begin
            rf[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_reg    <= '0;
            o_flag   <= 1'b0;
            z_flag   <= 1'b0;
            n_flag   <= 1'b0;
            addr_out <= '0;
            mem_rw   <= 1'b1;
            data_out <= '0;
        end else begin
            if (en) begin
                y_reg  <= y;
                z_flag <= (y == '0);
                n_flag <= y[N-1];
                o_flag <= ovf;
            end
            if (addr_en) begin
                addr_out <= y;
                mem_rw   <= rw;
            end
            if (data_en)
                data_out <= rf[rb];
        end
    end

    assign dout = oe ? y_reg : '0;

endmodule

// File: tb/tb_datapath_core.sv
// Directed vector table plus reset and ALU-sweep sequences for datapath_core.
module tb_datapath_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din, offset;
    logic [2:0]  waddr, ra, rb, op;
    logic        write, reada, readb, ie, mov_sel, bypassa, bypassb;
    logic        en, oe, addr_en, data_en, rw;
    logic [15:0] dout, addr_out, data_out;
    logic        mem_rw, o_flag, z_flag, n_flag;

    int pass_cnt = 0;
    int total    = 0;

    datapath_core #(.M(3), .N(16)) dut (
        .clk(clk), .rst(rst), .din(din), .offset(offset), .waddr(waddr),
        .ra(ra), .rb(rb), .op(op), .write(write), .reada(reada), .readb(readb),
        .ie(ie), .mov_sel(mov_sel), .bypassa(bypassa), .bypassb(bypassb),
        .en(en), .oe(oe), .addr_en(addr_en), .data_en(data_en), .rw(rw),
        .dout(dout), .addr_out(addr_out), .data_out(data_out), .mem_rw(mem_rw),
        .o_flag(o_flag), .z_flag(z_flag), .n_flag(n_flag)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] W  = 12'h001, RA = 12'h002, RB = 12'h004, IE = 12'h008;
    localparam logic [11:0] MV = 12'h010, BA = 12'h020, BB = 12'h040, EN = 12'h080;
    localparam logic [11:0] OE = 12'h100, AE = 12'h200, DE = 12'h400, RW = 12'h800;

    typedef struct {
        logic        r;
        logic [11:0] ctl;
        logic [15:0] d, off;
        logic [2:0]  wa, a, b, o;
        logic [1:0]  chk;
        logic [15:0] e_dout;
        logic        e_o, e_z, e_n;
        logic [15:0] e_addr, e_data;
        logic        e_rw;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [11:0] c,
                                input logic [15:0] d, input logic [15:0] off,
                                input logic [2:0] wa, input logic [2:0] a,
                                input logic [2:0] b, input logic [2:0] o);
        vec_t x;
        x = '{default: '0};
        x.r = r; x.ctl = c; x.d = d; x.off = off;
        x.wa = wa; x.a = a; x.b = b; x.o = o;
        return x;
    endfunction

    function automatic vec_t ef(input vec_t x, input logic [15:0] dv,
                                input logic fo, input logic fz, input logic fn);
        x.chk[0] = 1'b1; x.e_dout = dv; x.e_o = fo; x.e_z = fz; x.e_n = fn;
        return x;
    endfunction

    function automatic vec_t em(input vec_t x, input logic [15:0] ad,
                                input logic [15:0] dt, input logic mrw);
        x.chk[1] = 1'b1; x.e_addr = ad; x.e_data = dt; x.e_rw = mrw;
        return x;
    endfunction

    task automatic apply(input vec_t v);
        rst = v.r; din = v.d; offset = v.off;
        waddr = v.wa; ra = v.a; rb = v.b; op = v.o;
        {rw, data_en, addr_en, oe, en, bypassb, bypassa, mov_sel, ie, readb, reada, write} = v.ctl;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic check_flags(input string tag, input int idx, input logic [15:0] ed,
                               input logic eo, input logic ez, input logic en_);
        check({tag, " dout"}, idx, dout, ed);
        check({tag, " o_flag"}, idx, 16'(o_flag), 16'(eo));
        check({tag, " z_flag"}, idx, 16'(z_flag), 16'(ez));
        check({tag, " n_flag"}, idx, 16'(n_flag), 16'(en_));
    endtask

    task automatic check_mem(input string tag, input int idx, input logic [15:0] ea,
                             input logic [15:0] ed, input logic erw);
        check({tag, " addr_out"}, idx, addr_out, ea);
        check({tag, " data_out"}, idx, data_out, ed);
        check({tag, " mem_rw"}, idx, 16'(mem_rw), 16'(erw));
    endtask

    // Reference ALU: overflow taken from the signed result leaving the 16-bit range.
    task automatic ref_alu(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] y, output logic ov);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = 0;
        ov = 1'b0;
        case (o)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd7: r = sa + 1;
            default: r = 0;
        endcase
        case (o)
            3'd0, 3'd1, 3'd7: begin
                y  = 16'(r);
                ov = (r > 32767) || (r < -32768);
            end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = ~a;
            default: y = a;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] va, vb, ey;
        logic        eov;

        apply(mk(1'b1, 12'h000, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0));
        repeat (2) @(posedge clk);
        #1;
        check_flags("por", 0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_mem("por", 0, 16'h0000, 16'h0000, 1'b1);

        tbl.push_back(mk(1'b0, IE|W, 16'h7FFF, 16'h0, 3'd1, 3'd0, 3'd0, 3'd0));
        tbl.push_back(mk(1'b0, IE|W, 16'h0001, 16'h0, 3'd2, 3'd0, 3'd0, 3'd0));
        tbl.push_back(ef(mk(1'b0, RA|RB|EN|OE, 16'h0, 16'h0, 3'd0, 3'd1, 3'd2, 3'd0), 16'h8000, 1'b1, 1'b0, 1'b1));
        tbl.push_back(ef(mk(1'b0, MV|W, 16'h0, 16'h1234, 3'd3, 3'd0, 3'd0, 3'd0), 16'h0000, 1'b1, 1'b0, 1'b1));
        tbl.push_back(ef(mk(1'b0, RA|RB|EN|OE, 16'h0, 16'h0, 3'd0, 3'd3, 3'd3, 3'd1), 16'h0000, 1'b0, 1'b1, 1'b0));
        tbl.push_back(ef(mk(1'b0, RA|RB|OE, 16'h0, 16'h0, 3'd0, 3'd1, 3'd2, 3'd0), 16'h0000, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, MV|W, 16'h0, 16'hFFF9, 3'd4, 3'd0, 3'd0, 3'd0));
        tbl.push_back(ef(mk(1'b0, RA|EN|OE, 16'h0, 16'h0, 3'd0, 3'd4, 3'd0, 3'd6), 16'hFFF9, 1'b0, 1'b0, 1'b1));
        tbl.push_back(ef(mk(1'b0, BA|W|EN|OE, 16'h0, 16'hFFF9, 3'd5, 3'd0, 3'd0, 3'd7), 16'hFFFA, 1'b0, 1'b0, 1'b1));
        tbl.push_back(ef(mk(1'b0, MV|W|RA|EN|OE, 16'h0, 16'h0042, 3'd5, 3'd5, 3'd0, 3'd6), 16'hFFFA, 1'b0, 1'b0, 1'b1));
        tbl.push_back(ef(mk(1'b0, RA|EN|OE, 16'h0, 16'h0, 3'd0, 3'd5, 3'd0, 3'd6), 16'h0042, 1'b0, 1'b0, 1'b0));
        tbl.push_back(em(ef(mk(1'b0, RA|RB|AE|DE, 16'h0, 16'h0, 3'd0, 3'd1, 3'd2, 3'd6), 16'h0000, 1'b0, 1'b0, 1'b0),
                         16'h7FFF, 16'h0001, 1'b0));
        tbl.push_back(em(ef(mk(1'b0, BA|BB|RB|AE|DE|RW, 16'h0, 16'h5555, 3'd0, 3'd0, 3'd1, 3'd6), 16'h0000, 1'b0, 1'b0, 1'b0),
                         16'h5555, 16'h7FFF, 1'b1));
        tbl.push_back(mk(1'b0, MV|W, 16'h0, 16'hFFFF, 3'd6, 3'd0, 3'd0, 3'd0));
        tbl.push_back(ef(mk(1'b0, RA|BB|EN|OE, 16'h0, 16'h0001, 3'd0, 3'd6, 3'd0, 3'd0), 16'h0000, 1'b0, 1'b1, 1'b0));
        tbl.push_back(ef(mk(1'b0, RA|EN|OE, 16'h0, 16'h0, 3'd0, 3'd6, 3'd0, 3'd7), 16'h0000, 1'b0, 1'b1, 1'b0));
        tbl.push_back(ef(mk(1'b0, BA|RB|EN|OE, 16'h0, 16'h8000, 3'd0, 3'd0, 3'd2, 3'd1), 16'h7FFF, 1'b1, 1'b0, 1'b0));
        tbl.push_back(em(ef(mk(1'b0, BA|RB|W|EN|OE|AE|DE, 16'h0, 16'h0010, 3'd7, 3'd0, 3'd2, 3'd0), 16'h0011, 1'b0, 1'b0, 1'b0),
                         16'h0011, 16'h0001, 1'b0));
        tbl.push_back(ef(mk(1'b0, RA|EN|OE, 16'h0, 16'h0, 3'd0, 3'd7, 3'd0, 3'd6), 16'h0011, 1'b0, 1'b0, 1'b0));
        // Reset held across an edge with a write strobe pending: the write must not land.
        tbl.push_back(em(ef(mk(1'b1, IE|W|EN|OE, 16'hABCD, 16'h0, 3'd1, 3'd0, 3'd0, 3'd0), 16'h0000, 1'b0, 1'b0, 1'b0),
                         16'h0000, 16'h0000, 1'b1));
        for (int r = 0; r < 8; r++)
            tbl.push_back(ef(mk(1'b0, RA|EN|OE, 16'h0, 16'h0, 3'd0, 3'(r), 3'd0, 3'd6), 16'h0000, 1'b0, 1'b1, 1'b0));

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            @(posedge clk);
            #1;
            if (tbl[i].chk[0]) check_flags("vec", i, tbl[i].e_dout, tbl[i].e_o, tbl[i].e_z, tbl[i].e_n);
            if (tbl[i].chk[1]) check_mem("vec", i, tbl[i].e_addr, tbl[i].e_data, tbl[i].e_rw);
        end

        // Asynchronous reset between edges, then the first edge after release.
        @(negedge clk);
        apply(mk(1'b0, BA|EN|OE|AE, 16'h0, 16'h8000, 3'd0, 3'd0, 3'd0, 3'd6));
        @(posedge clk);
        #1;
        check_flags("pre_arst", 0, 16'h8000, 1'b0, 1'b0, 1'b1);
        check_mem("pre_arst", 0, 16'h8000, 16'h0000, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_flags("arst", 0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_mem("arst", 0, 16'h0000, 16'h0000, 1'b1);
        @(negedge clk);
        apply(mk(1'b0, BA|EN|OE, 16'h0, 16'h0001, 3'd0, 3'd0, 3'd0, 3'd6));
        @(posedge clk);
        #1;
        check_flags("post_arst", 0, 16'h0001, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            if (i < 8) begin
                va = 16'hFFFF;
                vb = 16'h0001;
            end else if (i < 16) begin
                va = 16'h7FFF;
                vb = 16'h8000;
            end else begin
                va = 16'($urandom);
                vb = 16'($urandom);
            end
            @(negedge clk);
            apply(mk(1'b0, MV|W, 16'h0, vb, 3'd6, 3'd0, 3'd0, 3'd0));
            @(negedge clk);
            apply(mk(1'b0, BA|RB|EN|OE, 16'h0, va, 3'd0, 3'd0, 3'd6, 3'(i)));
            @(posedge clk);
            #1;
            ref_alu(3'(i), va, vb, ey, eov);
            check_flags("sweep", i, ey, eov, ey == 16'h0000, ey[15]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/datapath_core.md
Name: datapath_core

Overview:
- Execution datapath directly downstream of the microcode sequencer.
- Contains the register file, operand muxes, 3-bit ALU, flag register and memory address/data output registers.
- Consumes the sequencer's control word (op, ra, rb, waddr, offset and strobes) and returns o_flag, z_flag and n_flag to it.
- One operation per clock; results and flags are registered.

Parameters:
- M, 3, register address width; the file holds 2**M registers.
- N, 16, data width of registers, ALU, offset and memory buses.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  N  data from memory; the write source when ie=1.
- offset  in  N  sign-extended immediate from the sequencer.
- waddr  in  M  register file write address.
- ra  in  M  read address, port A.
- rb  in  M  read address, port B.
- op  in  3  ALU operation.
- write  in  1  register file write enable.
- reada  in  1  port A read enable; when 0 the port reads 0.
- readb  in  1  port B read enable; when 0 the port reads 0.
- ie  in  1  input enable: write data = din.
- mov_sel  in  1  write data = offset (used when ie=0).
- bypassa  in  1  ALU A operand = offset instead of port A.
- bypassb  in  1  ALU B operand = offset instead of port B.
- en  in  1  latch ALU result into y_reg and update flags.
- oe  in  1  output enable for dout.
- addr_en  in  1  latch the ALU result into addr_out.
- data_en  in  1  latch port B into data_out.
- rw  in  1  memory direction, 1=read; registered with addr_en.
- dout  out  N  y_reg when oe=1, else 0.
- addr_out  out  N  memory address register.
- data_out  out  N  memory write data register.
- mem_rw  out  1  registered rw.
- o_flag  out  1  registered signed overflow.
- z_flag  out  1  registered zero.
- n_flag  out  1  registered negative (MSB).

Behaviour:
- Reset (asynchronous, active-high): all registers, y_reg, addr_out, data_out and flags are cleared to 0; mem_rw is set to 1 (read, never a spurious write). While rst=1, write strobes are ignored.
- Register file: 2**M x N, one write port and two combinational read ports. Every register is writable, including address 0.
- Write data priority: ie → din; else mov_sel → offset; else the combinational ALU result y. The write commits on the clk edge when write=1.
- Same-cycle read and write of one address: the read returns the old value (read-before-write, no forwarding). The new value is visible the next cycle.
- Operands: A = bypassa ? offset : (reada ? rf[ra] : 0). B = bypassb ? offset : (readb ? rf[rb] : 0).
- ALU op codes:
  - 000 A+B
  - 001 A-B
  - 010 A&B
  - 011 A|B
  - 100 A^B
  - 101 ~A
  - 110 A (mov)
  - 111 A+1
- Results wrap modulo 2**N.
- Overflow, two's complement: for add and inc, the operands have the same sign and the result sign differs. For sub, A and B signs differ and the result sign differs from A. For the logic ops and mov, o=0.
- en=1 at the edge: y_reg <= y; z_flag <= (y==0); n_flag <= y[N-1]; o_flag <= overflow.
- en=0: y_reg and all flags hold.
- Flags are valid one cycle after the en edge. The sequencer samples them through its own registered mux, so the total flag latency to a branch decision is 2 cycles.
- addr_en=1: addr_out <= y and mem_rw <= rw. Otherwise both hold.
- data_en=1: data_out <= B-port register value (rf[rb], ignoring bypassb).
- Simultaneous strobes are independent: write, en, addr_en and data_en may all be asserted in one cycle and each acts on the same y.
- dout is combinational from y_reg and oe only; it has no path from din.
- Reset asserted mid-operation clears state immediately; on release the first edge behaves as after power-up.

Test Plan:
- Reset: assert rst mid-run → all outputs 0, mem_rw=1. Then read all registers with reada=1 → every one reads 0.
- Load and add:
  - ie=1, write=1, waddr=1, din=0x7FFF; then waddr=2, din=0x0001.
  - Then ra=1, rb=2, op=000, en=1, oe=1 → next cycle dout=0x8000, o=1, n=1, z=0.
- Subtract to zero: r3=0x1234, ra=rb=3, op=001, en=1 → z=1, n=0, o=0. Repeat with en=0 → flags hold.
- Immediate and mov:
  - mov_sel=1, offset=0xFFF9, write=1, waddr=4 → r4=0xFFF9.
  - bypassa=1, op=111, write=1, waddr=5 → r5=0xFFFA.
  - Same-cycle read of r5 → old value.
- Memory regs: ra=1, op=110, addr_en=1, rw=0, rb=2, data_en=1 → addr_out=0x7FFF, mem_rw=0, data_out=0x0001. With oe=0 → dout=0.
- Op sweep: random A/B for all 8 ops against a reference model, 1000 cycles, checking y, flags and wrap at 0xFFFF+1=0.
